// File: rtl/flag_request_queue.sv
// flag_request_queue: counts request pulses and issues them one at a time as
// single-cycle flags into a flag/ack crossing, only while it reports not-busy.
// Tracks backlog depth and a sticky overflow for requests lost to saturation.
module flag_request_queue #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 PULSE_IN,
  input  logic                 BUSY_IN,
  input  logic                 CLEAR_OVERFLOW,
  output logic                 FLAG_OUT,
  output logic [CNT_WIDTH-1:0] PENDING,
  output logic                 EMPTY,
  output logic                 OVERFLOW
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRE  = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_r;
  logic                 flag_r;
  logic [CNT_WIDTH-1:0] pending_r;
  logic                 empty_r;
  logic                 overflow_r;

  logic                 issue_s;
  logic                 drop_s;
  logic [CNT_WIDTH-1:0] pending_next_s;

  // Decide whether a flag is issued this edge; the IDLE gate on BUSY_IN also
  // protects against a double issue right after a reset.
  always_comb begin
    issue_s = 1'b0;
    if ((state_r == IDLE) && (pending_r != CNT_ZERO) && !BUSY_IN) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next backlog value: a simultaneous request and issue cancel out, and a
  // request arriving at full backlog is dropped and recorded as an overflow.
  always_comb begin
    pending_next_s = pending_r;
    drop_s         = 1'b0;
    case ({PULSE_IN, issue_s})
      2'b10: begin
        if (pending_r == CNT_MAX) begin
          pending_next_s = pending_r;
          drop_s         = 1'b1;
        end else begin
          pending_next_s = pending_r + CNT_ONE;
          drop_s         = 1'b0;
        end
      end
      2'b01: begin
        pending_next_s = pending_r - CNT_ONE;
        drop_s         = 1'b0;
      end
      default: begin
        pending_next_s = pending_r;
        drop_s         = 1'b0;
      end
    endcase
  end

  // Issue FSM: one flag cycle, then one guard cycle that ignores BUSY_IN
  // while the crossing's busy indication catches up.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      flag_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            state_r <= FIRE;
            flag_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            flag_r  <= 1'b0;
          end
        end
        FIRE: begin
          state_r <= GUARD;
          flag_r  <= 1'b0;
        end
        GUARD: begin
          state_r <= IDLE;
          flag_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          flag_r  <= 1'b0;
        end
      endcase
    end
  end

  // Backlog counter, its registered empty indication, and sticky overflow
  // where a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_r  <= CNT_ZERO;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      empty_r   <= (pending_next_s == CNT_ZERO);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (CLEAR_OVERFLOW) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign FLAG_OUT = flag_r;
  assign PENDING  = pending_r;
  assign EMPTY    = empty_r;
  assign OVERFLOW = overflow_r;

endmodule
